// File: rtl/mct_pkg.sv
// Shared definitions for the memory controller and its clients:
// size codes, controller state encoding, client port ids.
package mct_pkg;

    localparam logic [1:0] CU_BYTE = 2'h0;
    localparam logic [1:0] CU_HALF = 2'h1;
    localparam logic [1:0] CU_WORD = 2'h3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    typedef enum logic {
        PORT_IF,
        PORT_MM
    } port_t;

    // Code 2 is unused by the clients and is treated as a word.
    function automatic logic [2:0] cu_nbytes(input logic [1:0] cu);
        case (cu)
            CU_BYTE: return 3'd1;
            CU_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mct.sv
// Memory controller: arbitrates fetch and MEM clients onto a byte-wide RAM,
// serializing each request into 1/2/4 little-endian byte accesses.
module mct
    import mct_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_a,
    input  logic              if_e,
    output logic [31:0]       if_n_o,
    output logic              if_ok,
    input  logic [ADDR_W-1:0] mm_a,
    input  logic [31:0]       mm_n_i,
    input  logic              mm_wr,
    input  logic              mm_e,
    input  logic [1:0]        mm_cu,
    output logic [31:0]       mm_n_o,
    output logic              mm_ok,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              ram_wr
);

    state_t            state_q, state_d;
    port_t             port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        nb_q, nb_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       dat_q, dat_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic [31:0]       if_n_q, if_n_d;
    logic [31:0]       mm_n_q, mm_n_d;
    logic              if_ok_q, if_ok_d;
    logic              mm_ok_q, mm_ok_d;
    logic [1:0]        lane;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            port_q     <= PORT_IF;
            addr_q     <= '0;
            nb_q       <= '0;
            cnt_q      <= '0;
            dat_q      <= '0;
            asm_q      <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            if_n_q     <= '0;
            mm_n_q     <= '0;
            if_ok_q    <= 1'b0;
            mm_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            addr_q     <= addr_d;
            nb_q       <= nb_d;
            cnt_q      <= cnt_d;
            dat_q      <= dat_d;
            asm_q      <= asm_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
            if_n_q     <= if_n_d;
            mm_n_q     <= mm_n_d;
            if_ok_q    <= if_ok_d;
            mm_ok_q    <= mm_ok_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        addr_d     = addr_q;
        nb_d       = nb_q;
        cnt_d      = cnt_q;
        dat_d      = dat_q;
        asm_d      = asm_q;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = 1'b0;
        if_n_d     = if_n_q;
        mm_n_d     = mm_n_q;
        if_ok_d    = 1'b0;
        mm_ok_d    = 1'b0;
        // Byte captured in RD cycle k+1 belongs to lane k.
        lane       = cnt_q[1:0] - 2'd1;

        case (state_q)
            S_IDLE: begin
                if (mm_e) begin
                    port_d  = PORT_MM;
                    addr_d  = mm_a;
                    nb_d    = cu_nbytes(mm_cu);
                    cnt_d   = '0;
                    asm_d   = '0;
                    ram_a_d = mm_a;
                    if (mm_wr) begin
                        ram_dout_d = mm_n_i[7:0];
                        dat_d      = {8'h00, mm_n_i[31:8]};
                        ram_wr_d   = 1'b1;
                        state_d    = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end else if (if_e) begin
                    port_d  = PORT_IF;
                    addr_d  = if_a;
                    nb_d    = 3'd4;
                    cnt_d   = '0;
                    asm_d   = '0;
                    ram_a_d = if_a;
                    state_d = S_RD;
                end
            end

            S_RD: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q != 3'd0) begin
                    asm_d[{lane, 3'b000} +: 8] = ram_din;
                end
                if (cnt_q + 3'd1 < nb_q) begin
                    ram_a_d = addr_q + ADDR_W'(cnt_q + 3'd1);
                end
                if (cnt_q == nb_q) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (port_q == PORT_IF) begin
                        if_n_d  = asm_d;
                        if_ok_d = 1'b1;
                    end else begin
                        mm_n_d  = asm_d;
                        mm_ok_d = 1'b1;
                    end
                end
            end

            S_WR: begin
                if (cnt_q + 3'd1 < nb_q) begin
                    cnt_d      = cnt_q + 3'd1;
                    ram_a_d    = addr_q + ADDR_W'(cnt_q + 3'd1);
                    ram_dout_d = dat_q[7:0];
                    dat_d      = {8'h00, dat_q[31:8]};
                    ram_wr_d   = 1'b1;
                end else begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (port_q == PORT_IF) begin
                        if_ok_d = 1'b1;
                    end else begin
                        mm_ok_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ram_a    = ram_a_q;
    assign ram_dout = ram_dout_q;
    assign ram_wr   = ram_wr_q;
    assign if_n_o   = if_n_q;
    assign mm_n_o   = mm_n_q;
    assign if_ok    = if_ok_q;
    assign mm_ok    = mm_ok_q;

endmodule
